// File: rtl/contador_rfwild_pkg.sv
// Shared types and defaults for the multi-channel RF-Wild counter.
package contador_rfwild_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } cnt_mode_t;

   localparam int DEFAULT_WIDTH    = 4;
   localparam int DEFAULT_CHANNELS = 2;

endpackage

// File: rtl/contador_rfwild_ch.sv
// Single counter channel: programmable terminal value, up/down/bounce/hold,
// clamped load, terminal-count pulse and sticky overflow flag.
module contador_rfwild_ch
   import contador_rfwild_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  cnt_mode_t        mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] modulus,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] contador,
   output logic             tc,
   output logic             ovf_sticky,
   output logic             dir
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic             tc_reg, tc_next;
   logic             ovf_reg, ovf_next;
   logic             dir_reg, dir_next;

   always_comb begin
      cnt_next = cnt_reg;
      dir_next = dir_reg;
      tc_next  = 1'b0;
      if (load) begin
         cnt_next = (load_val > modulus) ? modulus : load_val;
         dir_next = 1'b0;
      end else if (mode != MODE_HOLD && en) begin
         unique case (mode)
            MODE_UP: begin
               if (cnt_reg < modulus) begin
                  cnt_next = cnt_reg + ONE;
               end else begin
                  cnt_next = ZERO;
                  tc_next  = 1'b1;
               end
            end
            MODE_DOWN: begin
               if (cnt_reg == ZERO) begin
                  cnt_next = modulus;
                  tc_next  = 1'b1;
               end else if (cnt_reg > modulus) begin
                  cnt_next = modulus;
               end else begin
                  cnt_next = cnt_reg - ONE;
               end
            end
            MODE_BOUNCE: begin
               // Turnaround targets collapse to 0 when the terminal value is 0.
               if (!dir_reg) begin
                  if (cnt_reg < modulus) begin
                     cnt_next = cnt_reg + ONE;
                  end else begin
                     cnt_next = (modulus == ZERO) ? ZERO : modulus - ONE;
                     dir_next = 1'b1;
                     tc_next  = 1'b1;
                  end
               end else if (cnt_reg > modulus) begin
                  cnt_next = modulus;
               end else if (cnt_reg != ZERO) begin
                  cnt_next = cnt_reg - ONE;
               end else begin
                  cnt_next = (modulus == ZERO) ? ZERO : ONE;
                  dir_next = 1'b0;
                  tc_next  = 1'b1;
               end
            end
            default: begin
               cnt_next = cnt_reg;
            end
         endcase
      end
      ovf_next = tc_next | (ovf_reg & ~clr_flag);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
         tc_reg  <= 1'b0;
         ovf_reg <= 1'b0;
         dir_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         tc_reg  <= tc_next;
         ovf_reg <= ovf_next;
         dir_reg <= dir_next;
      end
   end

   assign contador   = cnt_reg;
   assign tc         = tc_reg;
   assign ovf_sticky = ovf_reg;
   assign dir        = dir_reg;

endmodule

// File: rtl/contador_rfwild_gen2.sv
// Multi-channel RF-Wild counter: one independent channel per slice of the buses.
module contador_rfwild_gen2
   import contador_rfwild_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int CHANNELS = DEFAULT_CHANNELS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       en,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS-1:0]       load,
   input  logic [WIDTH*CHANNELS-1:0] load_val,
   input  logic [WIDTH*CHANNELS-1:0] modulus,
   input  logic [CHANNELS-1:0]       clr_flags,
   output logic [WIDTH*CHANNELS-1:0] contador,
   output logic [CHANNELS-1:0]       tc,
   output logic [CHANNELS-1:0]       ovf_sticky,
   output logic [CHANNELS-1:0]       dir
);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      contador_rfwild_ch #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .en         (en[gi]),
         .mode       (cnt_mode_t'(mode[2*gi +: 2])),
         .load       (load[gi]),
         .load_val   (load_val[WIDTH*gi +: WIDTH]),
         .modulus    (modulus[WIDTH*gi +: WIDTH]),
         .clr_flag   (clr_flags[gi]),
         .contador   (contador[WIDTH*gi +: WIDTH]),
         .tc         (tc[gi]),
         .ovf_sticky (ovf_sticky[gi]),
         .dir        (dir[gi])
      );
   end

endmodule

// File: tb/tb_contador_rfwild_gen2.sv
// Directed test-plan scenarios followed by random traffic, checked each cycle
// against a per-channel integer reference model.
module tb_contador_rfwild_gen2;

   localparam int W = 4;
   localparam int C = 2;
   localparam bit [1:0] UP = 2'd0, DN = 2'd1, BN = 2'd2, HD = 2'd3;

   logic           clk = 1'b0;
   logic           reset;
   logic [C-1:0]   en, load, clr_flags;
   logic [2*C-1:0] mode;
   logic [W*C-1:0] load_val, modulus;
   logic [W*C-1:0] contador;
   logic [C-1:0]   tc, ovf_sticky, dir;

   int m_cnt[C], m_dir[C], m_ovf[C], m_tc[C];
   int errors = 0;
   int checks = 0;

   contador_rfwild_gen2 #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .load       (load),
      .load_val   (load_val),
      .modulus    (modulus),
      .clr_flags  (clr_flags),
      .contador   (contador),
      .tc         (tc),
      .ovf_sticky (ovf_sticky),
      .dir        (dir)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_ch(input int ch, input bit e, input bit [1:0] md, input bit ld,
                         input int lv, input int mv, input bit clr);
      logic [31:0] lvb, mvb;
      lvb = lv;
      mvb = mv;
      en[ch]              = e;
      mode[2*ch +: 2]     = md;
      load[ch]            = ld;
      load_val[W*ch +: W] = lvb[W-1:0];
      modulus[W*ch +: W]  = mvb[W-1:0];
      clr_flags[ch]       = clr;
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < C; ch++) begin
         m_cnt[ch] = 0; m_dir[ch] = 0; m_ovf[ch] = 0; m_tc[ch] = 0;
      end
   endtask

   // Behaviour of one clock edge, written from the counting rules in integers.
   task automatic model_edge();
      for (int ch = 0; ch < C; ch++) begin
         int m, c, md;
         m  = int'(modulus[W*ch +: W]);
         md = int'(mode[2*ch +: 2]);
         c  = m_cnt[ch];
         m_tc[ch] = 0;
         if (load[ch]) begin
            c = (int'(load_val[W*ch +: W]) < m) ? int'(load_val[W*ch +: W]) : m;
            m_dir[ch] = 0;
         end else if (md != 3 && en[ch]) begin
            if (md == 0) begin
               if (c < m) c = c + 1;
               else begin c = 0; m_tc[ch] = 1; end
            end else if (md == 1) begin
               if (c == 0) begin c = m; m_tc[ch] = 1; end
               else if (c > m) c = m;
               else c = c - 1;
            end else if (m_dir[ch] == 0) begin
               if (c < m) c = c + 1;
               else begin c = (m == 0) ? 0 : m - 1; m_dir[ch] = 1; m_tc[ch] = 1; end
            end else begin
               if (c > m) c = m;
               else if (c > 0) c = c - 1;
               else begin c = (m == 0) ? 0 : 1; m_dir[ch] = 0; m_tc[ch] = 1; end
            end
         end
         m_cnt[ch] = c;
         if (m_tc[ch] == 1) m_ovf[ch] = 1;
         else if (clr_flags[ch]) m_ovf[ch] = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      for (int ch = 0; ch < C; ch++) begin
         check_val($sformatf("%s_cnt%0d", tag, ch), 32'(contador[W*ch +: W]), m_cnt[ch]);
         check_val($sformatf("%s_tc%0d", tag, ch), 32'(tc[ch]), m_tc[ch]);
         check_val($sformatf("%s_ovf%0d", tag, ch), 32'(ovf_sticky[ch]), m_ovf[ch]);
         check_val($sformatf("%s_dir%0d", tag, ch), 32'(dir[ch]), m_dir[ch]);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
      $display("cyc %s: cnt0=%0d tc0=%0b ovf0=%0b dir0=%0b cnt1=%0d tc1=%0b ovf1=%0b dir1=%0b",
               tag, contador[3:0], tc[0], ovf_sticky[0], dir[0],
               contador[7:4], tc[1], ovf_sticky[1], dir[1]);
   endtask

   initial begin
      int s1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int s2[7]  = '{5, 4, 3, 2, 1, 0, 5};
      int s3[7]  = '{1, 2, 3, 2, 1, 0, 1};
      int d3[7]  = '{0, 0, 0, 1, 1, 1, 0};
      int t3[7]  = '{0, 0, 0, 1, 0, 0, 1};

      reset = 1'b1;
      en = '0; load = '0; clr_flags = '0; mode = '0; load_val = '0; modulus = '0;
      model_reset();
      #12;
      compare_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // Scenario 1: ch0 up to 9, ch1 idle
      set_ch(0, 1, UP, 0, 0, 9, 0);
      set_ch(1, 0, UP, 0, 0, 5, 0);
      for (int i = 0; i < 12; i++) begin
         cycle("s1");
         check_val("s1_seq", 32'(contador[3:0]), s1[i]);
         check_val("s1_tc", 32'(tc[0]), (s1[i] == 0) ? 1 : 0);
      end
      check_val("s1_ovf", 32'(ovf_sticky[0]), 1);
      check_val("s1_ch1", 32'(contador[7:4]), 0);

      // Scenario 2: ch1 down from 0
      set_ch(0, 0, UP, 0, 0, 9, 0);
      set_ch(1, 1, DN, 0, 0, 5, 0);
      for (int i = 0; i < 7; i++) begin
         cycle("s2");
         check_val("s2_seq", 32'(contador[7:4]), s2[i]);
         check_val("s2_tc", 32'(tc[1]), (s2[i] == 5) ? 1 : 0);
      end
      set_ch(1, 0, DN, 0, 0, 5, 0);

      // Scenario 3: ch0 bounce from 0
      set_ch(0, 0, BN, 1, 0, 3, 0);
      cycle("s3_ld");
      set_ch(0, 1, BN, 0, 0, 3, 0);
      for (int i = 0; i < 7; i++) begin
         cycle("s3");
         check_val("s3_seq", 32'(contador[3:0]), s3[i]);
         check_val("s3_dir", 32'(dir[0]), d3[i]);
         check_val("s3_tc", 32'(tc[0]), t3[i]);
      end

      // Scenario 4: load beats enable and is clamped
      set_ch(0, 1, UP, 1, 12, 9, 0);
      cycle("s4_ld");
      check_val("s4_clamp", 32'(contador[3:0]), 9);
      check_val("s4_ld_tc", 32'(tc[0]), 0);
      set_ch(0, 1, UP, 0, 0, 9, 0);
      cycle("s4_wrap");
      check_val("s4_wrap", 32'(contador[3:0]), 0);
      check_val("s4_wrap_tc", 32'(tc[0]), 1);

      // Scenario 5: hold and sticky flag
      set_ch(0, 0, UP, 1, 4, 9, 0);
      cycle("s5_ld");
      set_ch(0, 1, HD, 0, 0, 9, 0);
      for (int i = 0; i < 2; i++) begin
         cycle("s5_hold");
         check_val("s5_hold", 32'(contador[3:0]), 4);
         check_val("s5_hold_tc", 32'(tc[0]), 0);
      end
      set_ch(0, 0, UP, 1, 9, 9, 0);
      cycle("s5_ld9");
      set_ch(0, 1, UP, 0, 0, 9, 1);
      cycle("s5_setclr");
      check_val("s5_setclr", 32'(ovf_sticky[0]), 1);
      set_ch(0, 0, UP, 0, 0, 9, 1);
      cycle("s5_clr");
      check_val("s5_clr", 32'(ovf_sticky[0]), 0);

      // Scenario 6: M=0, then asynchronous reset mid-count
      set_ch(0, 1, UP, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle("s6_m0");
         check_val("s6_m0_cnt", 32'(contador[3:0]), 0);
         check_val("s6_m0_tc", 32'(tc[0]), 1);
      end
      set_ch(0, 0, UP, 1, 6, 9, 0);
      cycle("s6_ld");
      set_ch(0, 1, UP, 0, 0, 9, 0);
      cycle("s6_7");
      check_val("s6_at7", 32'(contador[3:0]), 7);
      #2;
      reset = 1'b1;
      #1;
      check_val("s6_async_cnt", 32'(contador), 0);
      check_val("s6_async_flags", 32'({tc, ovf_sticky, dir}), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Random traffic on both channels
      for (int n = 0; n < 400; n++) begin
         for (int ch = 0; ch < C; ch++) begin
            set_ch(ch, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
         end
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/contador_rfwild_gen2.md
# contador_rfwild_gen2

Second-generation RF-Wild counter: `CHANNELS` independent `WIDTH`-bit counters, each with a programmable terminal value and its own mode (up, down, bounce, hold), parallel load, count enable, terminal-count pulse and sticky overflow flag. It replaces the fixed 4-bit free-running counter in the chip's timing path. Channel 0 with `WIDTH=4`, mode up and `modulus=15` reproduces the legacy count sequence.

## Interface
- `WIDTH`, 4, bits per channel counter (≥2)
- `CHANNELS`, 2, number of independent counter channels (≥1)

- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  CHANNELS  per-channel count enable
- `mode`  in  2·CHANNELS  per-channel mode, channel i at [2i+1:2i]: 00 up, 01 down, 10 bounce, 11 hold
- `load`  in  CHANNELS  per-channel synchronous load strobe
- `load_val`  in  WIDTH·CHANNELS  load value, channel i at [WIDTH·i +: WIDTH]
- `modulus`  in  WIDTH·CHANNELS  terminal value; channel counts within 0..modulus
- `clr_flags`  in  CHANNELS  per-channel clear of `ovf_sticky`
- `contador`  out  WIDTH·CHANNELS  count value, channel i at [WIDTH·i +: WIDTH]
- `tc`  out  CHANNELS  one-cycle terminal-count pulse
- `ovf_sticky`  out  CHANNELS  set by `tc`, held until cleared
- `dir`  out  CHANNELS  bounce direction: 0 up, 1 down

## Operation
- Reset: `contador`=0, `tc`=0, `ovf_sticky`=0, `dir`=0 on all channels. Reset acts asynchronously on assertion.
- Per-channel priority: `load` > hold mode > `en` > idle.
  - In the load, hold and idle cases `tc` is 0.
- Load:
  - next = min(`load_val`, `modulus`).
  - `dir` ← 0.
  - No `tc`, in every mode including hold.
- Up mode (with `en`):
  - cnt < M: cnt+1.
  - cnt ≥ M: 0 with `tc`=1.
- Down mode (with `en`):
  - cnt = 0: M with `tc`=1.
  - cnt > M: M with no `tc`.
  - Otherwise: cnt−1.
- Bounce mode (with `en`):
  - dir=0, cnt < M: cnt+1.
  - dir=0, cnt ≥ M: next = M−1 (0 if M=0), `dir` ← 1, `tc`=1.
  - dir=1, cnt > M: M with no `tc`.
  - dir=1, cnt > 0: cnt−1.
  - dir=1, cnt = 0: next = 1 (0 if M=0), `dir` ← 0, `tc`=1.
- M=0 with `en` in up, down or bounce: count stays 0 and `tc`=1 every enabled cycle.
- Mode changes take effect on the next edge. `dir` is kept when leaving bounce.
- `ovf_sticky`: set when `tc` is generated. `clr_flags` clears it. Simultaneous set and clear leaves it set.
- All arithmetic is unsigned `WIDTH`-bit. No value outside 0..2^WIDTH−1 is ever produced.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency is 1 cycle: inputs sampled at edge k appear on `contador`, `tc`, `dir` and `ovf_sticky` after edge k.
- `tc` is high for exactly the cycle in which `contador` shows the post-wrap or post-turnaround value.
- Reset asserted mid-count forces all outputs to reset values immediately. Release of `reset` is synchronised by the integrating level. The first count occurs on the first edge where `reset`=0.
- Channels never interact. Simultaneous events on different channels are independent.

## Structure
- Package `contador_rfwild_pkg` holds:
  - `typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_HOLD} cnt_mode_t`
  - default `WIDTH` and `CHANNELS` localparams.
- Sub-module `contador_rfwild_ch` is a single-channel counter holding `contador`, `tc`, `ovf_sticky` and `dir`. The top level instantiates it `CHANNELS` times in a generate loop and does only bus slicing.
- Golden model `contador_rfwild_gen2_model` has identical ports. It is compared against the netlist per channel through the existing checker.

## Test plan
All scenarios use `WIDTH`=4 and `CHANNELS`=2.

1. Release reset. Ch0 up, M=9, `en`=1 for 12 cycles → `contador` 1..9, 0, 1, 2. `tc` high only with 0 shown. `ovf_sticky`[0]=1. Ch1 (`en`=0) stays 0.
2. Ch1 down, M=5, start 0 → 5, 4, 3, 2, 1, 0, 5. `tc` with each 5 shown.
3. Ch0 bounce, M=3 → 1, 2, 3, 2, 1, 0, 1. `tc` with 2 (after 3) and with 1 (after 0). `dir` flips to 1 with the first 2 and back to 0 with the final 1.
4. Load priority and clamping:
   - Ch0 M=9, `load_val`=12, `load`=1 together with `en`=1 → `contador`=9, `tc`=0.
   - Next cycle, up mode → 0 with `tc`=1.
5. Hold and sticky flag:
   - Ch0 hold, `en`=1 → value frozen, `tc`=0.
   - `clr_flags`[0] in the same cycle as a `tc` → `ovf_sticky` stays 1.
   - `clr_flags`[0] alone → 0.
6. M=0 and reset:
   - M=0, up, `en`=1 → `contador`=0, `tc`=1 every cycle.
   - Assert `reset` between clock edges mid-count at value 7 → all outputs 0 immediately, with no clock edge needed.
